fetch_unit: RTL



---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction front end: datapath width, default
// reset PC, instruction size, the canonical NOP encoding and the fetch FSM
// state type.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    // IDLE  : one cycle after reset, nothing issued
    // RUN   : normal sequential fetch
    // DRAIN : fetching from a redirect target while old responses are dropped
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {instruction, pc} pairs between instruction
// memory and decode. Push and pop may happen in the same cycle, including when
// the FIFO is full (the pop frees the slot) or empty (pop is ignored).
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        synchronous flush, empties the FIFO
//   push         write push_data at the tail
//   push_data    WIDTH-bit entry
//   pop          remove the head entry (ignored when empty)
//   head_data    head entry, zero when empty
//   empty        FIFO holds no entries
//   count        number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);

    // Pointers and occupancy. DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the head output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

    // The fetch credit scheme must never push into a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Holds the PC, issues in-order requests to
// instruction memory, buffers returned instructions with their PCs and hands
// them to decode over valid/ready. A redirect (taken branch/jump) flushes the
// buffer, marks every in-flight request stale and restarts at the target.
//
// Optional build macro: FETCH_BYPASS_EN
//   When defined, a non-stale response arriving while the FIFO is empty is
//   presented to decode in the same cycle; it is only buffered if decode does
//   not accept it. Without it every response passes through the FIFO.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   redirect_valid   taken branch/jump this cycle
//   redirect_pc      redirect target (bits [1:0] ignored)
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address (current PC)
//   imem_rsp_valid   in-order response valid, no backpressure
//   imem_rsp_data    fetched instruction
//   dec_valid        instruction available to decode
//   dec_ready        decode accepts
//   dec_instr        instruction presented to decode
//   dec_pc           PC of the instruction presented to decode
// ---------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   stale;
    logic [CW-1:0]   stale_next;
    logic [CW:0]     credits_used;

    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              bypass_hit;
    logic              bypass_taken;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;

    assign target_pc = redirect_pc & ~XLEN'(3);

    // Requests in flight plus buffered instructions may never exceed DEPTH,
    // which is what keeps the FIFO from overflowing.
    assign credits_used   = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = (state != IDLE) && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is dropped if it belongs to a pre-redirect request, including
    // one arriving in the redirect cycle itself.
    assign rsp_drop = imem_rsp_valid && (redirect_valid || (stale != '0));
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    assign inflight_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    // A redirect turns everything still in flight after this edge stale,
    // including a request accepted in the same cycle.
    always_comb begin
        stale_next = stale;
        if (redirect_valid) begin
            stale_next = inflight_next;
        end else if (imem_rsp_valid && (stale != '0)) begin
            stale_next = stale - CW'(1);
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass_hit   = fifo_empty && rsp_keep;
    assign bypass_taken = bypass_hit && dec_ready;
`else
    assign bypass_hit   = 1'b0;
    assign bypass_taken = 1'b0;
`endif

    assign fifo_push = rsp_keep && !bypass_taken;
    assign fifo_pop  = !fifo_empty && dec_ready;

    assign dec_valid = !fifo_empty || bypass_hit;
    assign dec_instr = bypass_hit ? imem_rsp_data : fifo_head[2*XLEN-1:XLEN];
    assign dec_pc    = bypass_hit ? rsp_pc        : fifo_head[XLEN-1:0];

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data ({imem_rsp_data, rsp_pc}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: stay in DRAIN for as long as stale responses are owed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = RUN;
            RUN, DRAIN: state_next = (stale_next != '0) ? DRAIN : RUN;
            default:    state_next = IDLE;
        endcase
    end

    // PC, response PC and credit counters; a redirect overrides increments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            stale    <= '0;
        end else begin
            if (redirect_valid) begin
                pc     <= target_pc;
                rsp_pc <= target_pc;
            end else begin
                if (req_fire) pc     <= pc + XLEN'(INSTR_BYTES);
                if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
            end
            inflight <= inflight_next;
            stale    <= stale_next;
        end
    end

endmodule
